// File: rtl/memory_lsu_pkg.sv
// Shared definitions for the memory/load-store stage.
//   - load/store size encodings (funct3 of the memory instruction)
//   - LSU bus FSM states
//   - writeback source select codes carried through the stage
package memory_lsu_pkg;

  localparam logic [2:0] SZ_B  = 3'b000;
  localparam logic [2:0] SZ_H  = 3'b001;
  localparam logic [2:0] SZ_W  = 3'b010;
  localparam logic [2:0] SZ_D  = 3'b011;
  localparam logic [2:0] SZ_BU = 3'b100;
  localparam logic [2:0] SZ_HU = 3'b101;
  localparam logic [2:0] SZ_WU = 3'b110;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_REQ  = 2'd1,
    LSU_WAIT = 2'd2
  } lsu_state_e;

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;

endpackage

// File: rtl/memory_lsu_if.sv
// Data-memory bus between the LSU (master) and memory (slave).
//   mem_req/mem_we/mem_addr/mem_be/mem_wdata : request, master -> slave
//   mem_ready                                : request accepted, slave -> master
//   mem_valid/mem_rdata                      : response, slave -> master
interface memory_lsu_if #(
  parameter int XLEN = 32
) ();
  localparam int NB = XLEN / 8;

  logic            mem_req;
  logic            mem_we;
  logic [XLEN-1:0] mem_addr;
  logic [NB-1:0]   mem_be;
  logic [XLEN-1:0] mem_wdata;
  logic            mem_ready;
  logic            mem_valid;
  logic [XLEN-1:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_ready, mem_valid, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_ready, mem_valid, mem_rdata
  );
endinterface

// File: rtl/memory_lsu_align.sv
// Combinational access alignment for the LSU.
//   ex_size_i/ex_off_i -> misalign_o : alignment check on the execute-stage access
//   size_i/off_i       -> be_o       : byte enables for the registered access
//   wdata_i            -> wdata_o    : store data replicated across all lanes
//   rdata_i            -> ldata_o    : selected load lanes, sign/zero extended
module lsu_align
  import memory_lsu_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int NB   = XLEN / 8,
  parameter int OFFW = $clog2(NB)
) (
  input  logic [2:0]      ex_size_i,
  input  logic [OFFW-1:0] ex_off_i,
  output logic            misalign_o,
  input  logic [2:0]      size_i,
  input  logic [OFFW-1:0] off_i,
  input  logic [XLEN-1:0] wdata_i,
  input  logic [XLEN-1:0] rdata_i,
  output logic [NB-1:0]   be_o,
  output logic [XLEN-1:0] wdata_o,
  output logic [XLEN-1:0] ldata_o
);

  function automatic logic [XLEN-1:0] extend(input logic [XLEN-1:0] v,
                                             input logic [2:0]      size);
    logic signed [7:0]      b;
    logic signed [15:0]     h;
    logic signed [31:0]     w;
    logic        [XLEN-1:0] r;
    b = v[7:0];
    h = v[15:0];
    w = v[31:0];
    case (size)
      SZ_B:    r = XLEN'(b);
      SZ_H:    r = XLEN'(h);
      SZ_W:    r = XLEN'(w);
      SZ_BU:   r = XLEN'(v[7:0]);
      SZ_HU:   r = XLEN'(v[15:0]);
      SZ_WU:   r = XLEN'(v[31:0]);
      SZ_D:    r = v;
      default: r = '0;
    endcase
    return r;
  endfunction

  // Offset widened to 3 bits so the doubleword check is legal at XLEN=32.
  logic [2:0]      ex_off3;
  logic [XLEN-1:0] lane;

  assign ex_off3 = 3'(ex_off_i);

  // D and WU only exist on a 64-bit datapath; elsewhere they trap like misalignment.
  always_comb begin
    misalign_o = 1'b0;
    case (ex_size_i)
      SZ_B, SZ_BU: misalign_o = 1'b0;
      SZ_H, SZ_HU: misalign_o = ex_off3[0];
      SZ_W:        misalign_o = |ex_off3[1:0];
      SZ_WU:       misalign_o = (XLEN == 32) || (|ex_off3[1:0]);
      SZ_D:        misalign_o = (XLEN == 32) || (|ex_off3);
      default:     misalign_o = 1'b1;
    endcase
  end

  always_comb begin
    be_o = '0;
    case (size_i)
      SZ_B, SZ_BU: be_o = NB'(1) << off_i;
      SZ_H, SZ_HU: be_o = NB'(3) << off_i;
      SZ_W, SZ_WU: be_o = NB'(15) << off_i;
      SZ_D:        be_o = '1;
      default:     be_o = '0;
    endcase
  end

  // Replication lets memory pick the addressed lanes using be alone.
  always_comb begin
    wdata_o = wdata_i;
    case (size_i[1:0])
      2'b00:   wdata_o = {NB{wdata_i[7:0]}};
      2'b01:   wdata_o = {(NB/2){wdata_i[15:0]}};
      2'b10:   wdata_o = {(NB/4){wdata_i[31:0]}};
      default: wdata_o = wdata_i;
    endcase
  end

  assign lane    = rdata_i >> {off_i, 3'b000};
  assign ldata_o = extend(lane, size_i);

endmodule

// File: rtl/memory_lsu.sv
// Memory pipeline stage with load/store unit.
// Registers execute-stage results into *_m outputs and runs a request/response
// FSM toward data memory, holding the stage (busy_m) while a transaction is open.
//   clk, rst_n            : clock, async active-low reset
//   *_e inputs            : execute-stage results and memory control
//   *_m outputs           : registered stage outputs for writeback/hazard unit
//   mem                   : data-memory bus (master side)
//   stall_m / busy_m      : hold from hazard unit / stage occupied by bus access
module memory_lsu
  import memory_lsu_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int REG_W = 5,
  parameter int NB    = XLEN / 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pc_write_e,
  input  logic             rd_write_e,
  input  logic [1:0]       rd_write_src_e,
  input  logic             mem_read_e,
  input  logic             mem_write_e,
  input  logic [2:0]       mem_size_e,
  input  logic [REG_W-1:0] rd_e,
  input  logic [XLEN-1:0]  pc_e,
  input  logic [XLEN-1:0]  alu_res_e,
  input  logic [XLEN-1:0]  mem_data_e,
  output logic             pc_write_m,
  output logic [XLEN-1:0]  pc_next_addr_m,
  output logic             rd_write_m,
  output logic [1:0]       rd_write_src_m,
  output logic [REG_W-1:0] rd_m,
  output logic [XLEN-1:0]  pc_m,
  output logic [XLEN-1:0]  alu_res_m,
  output logic [XLEN-1:0]  mem_read_data_m,
  output logic             misalign_m,
  memory_lsu_if.master     mem,
  input  logic             stall_m,
  output logic             busy_m
);

  localparam int OFFW = $clog2(NB);

  logic             pc_write_q;
  logic             rd_write_q;
  logic [1:0]       rd_write_src_q;
  logic [REG_W-1:0] rd_q;
  logic [XLEN-1:0]  pc_q;
  logic [XLEN-1:0]  alu_res_q;
  logic [XLEN-1:0]  mem_data_q;
  logic             mem_read_q;
  logic             mem_write_q;
  logic [2:0]       mem_size_q;
  logic             misalign_q;
  logic [XLEN-1:0]  rdata_q;
  lsu_state_e       state_q;
  lsu_state_e       state_d;

  logic             le;
  logic             ex_misalign;
  logic [NB-1:0]    be_al;
  logic [XLEN-1:0]  wdata_al;
  logic [XLEN-1:0]  ldata_al;

  lsu_align #(
    .XLEN (XLEN),
    .NB   (NB),
    .OFFW (OFFW)
  ) u_align (
    .ex_size_i  (mem_size_e),
    .ex_off_i   (alu_res_e[OFFW-1:0]),
    .misalign_o (ex_misalign),
    .size_i     (mem_size_q),
    .off_i      (alu_res_q[OFFW-1:0]),
    .wdata_i    (mem_data_q),
    .rdata_i    (mem.mem_rdata),
    .be_o       (be_al),
    .wdata_o    (wdata_al),
    .ldata_o    (ldata_al)
  );

  assign le = !stall_m && !busy_m;

  // Execute -> memory stage boundary
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_write_q     <= 1'b0;
      rd_write_q     <= 1'b0;
      rd_write_src_q <= '0;
      rd_q           <= '0;
      pc_q           <= '0;
      alu_res_q      <= '0;
      mem_data_q     <= '0;
      mem_read_q     <= 1'b0;
      mem_write_q    <= 1'b0;
      mem_size_q     <= '0;
      misalign_q     <= 1'b0;
    end else if (le) begin
      pc_write_q     <= pc_write_e;
      // A trapping load must not write its destination register.
      rd_write_q     <= rd_write_e && !(mem_read_e && ex_misalign);
      rd_write_src_q <= rd_write_src_e;
      rd_q           <= rd_e;
      pc_q           <= pc_e;
      alu_res_q      <= alu_res_e;
      mem_data_q     <= mem_data_e;
      mem_read_q     <= mem_read_e;
      mem_write_q    <= mem_write_e;
      mem_size_q     <= mem_size_e;
      misalign_q     <= ex_misalign;
    end
  end

  // Bus response -> load data register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else if (state_q == LSU_WAIT && mem.mem_valid && mem_read_q) begin
      rdata_q <= ldata_al;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= LSU_IDLE;
    else        state_q <= state_d;
  end

  // A request is launched only on the capture edge, so a held instruction
  // cannot issue twice; mem_valid outside WAIT is ignored.
  always_comb begin
    state_d = state_q;
    case (state_q)
      LSU_IDLE: if (le && (mem_read_e || mem_write_e) && !ex_misalign) state_d = LSU_REQ;
      LSU_REQ:  if (mem.mem_ready) state_d = LSU_WAIT;
      LSU_WAIT: if (mem.mem_valid) state_d = LSU_IDLE;
      default:  state_d = LSU_IDLE;
    endcase
  end

  always_comb begin
    mem.mem_req = (state_q == LSU_REQ);
    mem.mem_we  = (state_q == LSU_REQ) && mem_write_q;
    mem.mem_be  = (state_q == LSU_REQ) ? be_al : '0;
    busy_m      = (state_q != LSU_IDLE);
  end

  assign mem.mem_addr  = {alu_res_q[XLEN-1:OFFW], OFFW'(0)};
  assign mem.mem_wdata = wdata_al;

  assign pc_write_m      = pc_write_q;
  assign pc_next_addr_m  = alu_res_q;
  assign rd_write_m      = rd_write_q;
  assign rd_write_src_m  = rd_write_src_q;
  assign rd_m            = rd_q;
  assign pc_m            = pc_q;
  assign alu_res_m       = alu_res_q;
  assign mem_read_data_m = rdata_q;
  assign misalign_m      = misalign_q;

endmodule

// File: tb/tb_memory_lsu.sv
module tb_memory_lsu;
  import memory_lsu_pkg::*;

  localparam int XLEN  = 32;
  localparam int REG_W = 5;

  logic             clk;
  logic             rst_n;
  logic             pc_write_e;
  logic             rd_write_e;
  logic [1:0]       rd_write_src_e;
  logic             mem_read_e;
  logic             mem_write_e;
  logic [2:0]       mem_size_e;
  logic [REG_W-1:0] rd_e;
  logic [XLEN-1:0]  pc_e;
  logic [XLEN-1:0]  alu_res_e;
  logic [XLEN-1:0]  mem_data_e;
  logic             pc_write_m;
  logic [XLEN-1:0]  pc_next_addr_m;
  logic             rd_write_m;
  logic [1:0]       rd_write_src_m;
  logic [REG_W-1:0] rd_m;
  logic [XLEN-1:0]  pc_m;
  logic [XLEN-1:0]  alu_res_m;
  logic [XLEN-1:0]  mem_read_data_m;
  logic             misalign_m;
  logic             stall_m;
  logic             busy_m;

  memory_lsu_if #(.XLEN(XLEN)) bus ();

  memory_lsu #(.XLEN(XLEN), .REG_W(REG_W)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .pc_write_e      (pc_write_e),
    .rd_write_e      (rd_write_e),
    .rd_write_src_e  (rd_write_src_e),
    .mem_read_e      (mem_read_e),
    .mem_write_e     (mem_write_e),
    .mem_size_e      (mem_size_e),
    .rd_e            (rd_e),
    .pc_e            (pc_e),
    .alu_res_e       (alu_res_e),
    .mem_data_e      (mem_data_e),
    .pc_write_m      (pc_write_m),
    .pc_next_addr_m  (pc_next_addr_m),
    .rd_write_m      (rd_write_m),
    .rd_write_src_m  (rd_write_src_m),
    .rd_m            (rd_m),
    .pc_m            (pc_m),
    .alu_res_m       (alu_res_m),
    .mem_read_data_m (mem_read_data_m),
    .misalign_m      (misalign_m),
    .mem             (bus),
    .stall_m         (stall_m),
    .busy_m          (busy_m)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int acc_cnt = 0;

  always @(posedge clk) begin
    if (bus.mem_req && bus.mem_ready) acc_cnt <= acc_cnt + 1;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_nop();
    pc_write_e     = 1'b0;
    rd_write_e     = 1'b0;
    rd_write_src_e = WB_ALU;
    mem_read_e     = 1'b0;
    mem_write_e    = 1'b0;
    mem_size_e     = SZ_W;
    rd_e           = '0;
    pc_e           = 32'h0000_0100;
    alu_res_e      = '0;
    mem_data_e     = '0;
  endtask

  task automatic do_store(input string tag, input logic [31:0] addr, input logic [31:0] data,
                          input logic [2:0] size, input logic [3:0] exp_be,
                          input logic [31:0] exp_wd);
    set_nop();
    mem_write_e = 1'b1;
    mem_size_e  = size;
    alu_res_e   = addr;
    mem_data_e  = data;
    tick();
    set_nop();
    check({tag, "_req"},   bus.mem_req, 1'b1);
    check({tag, "_we"},    bus.mem_we, 1'b1);
    check({tag, "_addr"},  bus.mem_addr, addr & 32'hFFFF_FFFC);
    check({tag, "_be"},    bus.mem_be, exp_be);
    check({tag, "_wdata"}, bus.mem_wdata, exp_wd);
    check({tag, "_busy"},  busy_m, 1'b1);
    bus.mem_ready = 1'b1;
    tick();
    bus.mem_ready = 1'b0;
    check({tag, "_wait_req"},  bus.mem_req, 1'b0);
    check({tag, "_wait_busy"}, busy_m, 1'b1);
    bus.mem_valid = 1'b1;
    tick();
    bus.mem_valid = 1'b0;
    check({tag, "_done_busy"}, busy_m, 1'b0);
  endtask

  task automatic do_load(input string tag, input logic [31:0] addr, input logic [2:0] size,
                         input logic [31:0] rdata, input logic [31:0] exp);
    set_nop();
    mem_read_e     = 1'b1;
    rd_write_e     = 1'b1;
    rd_write_src_e = WB_MEM;
    rd_e           = 5'd9;
    mem_size_e     = size;
    alu_res_e      = addr;
    tick();
    set_nop();
    check({tag, "_req"},  bus.mem_req, 1'b1);
    check({tag, "_we"},   bus.mem_we, 1'b0);
    check({tag, "_addr"}, bus.mem_addr, addr & 32'hFFFF_FFFC);
    bus.mem_ready = 1'b1;
    tick();
    bus.mem_ready = 1'b0;
    bus.mem_rdata = rdata;
    bus.mem_valid = 1'b1;
    tick();
    bus.mem_valid = 1'b0;
    check({tag, "_data"},  mem_read_data_m, exp);
    check({tag, "_busy"},  busy_m, 1'b0);
    check({tag, "_rdw"},   rd_write_m, 1'b1);
    check({tag, "_rd"},    rd_m, 5'd9);
    check({tag, "_mis"},   misalign_m, 1'b0);
  endtask

  logic [31:0] exp_alu;
  logic [31:0] exp_pc;
  logic [4:0]  exp_rd;
  logic        exp_pcw;
  int          acc0;

  initial begin
    rst_n         = 1'b0;
    stall_m       = 1'b0;
    bus.mem_ready = 1'b0;
    bus.mem_valid = 1'b0;
    bus.mem_rdata = '0;
    set_nop();
    tick();
    tick();
    check("rst_req",   bus.mem_req, 1'b0);
    check("rst_we",    bus.mem_we, 1'b0);
    check("rst_be",    bus.mem_be, 4'h0);
    check("rst_busy",  busy_m, 1'b0);
    check("rst_rdw",   rd_write_m, 1'b0);
    check("rst_pc",    pc_m, 32'h0);
    check("rst_alu",   alu_res_m, 32'h0);
    check("rst_rdata", mem_read_data_m, 32'h0);
    rst_n = 1'b1;
    tick();

    do_store("sb", 32'h0000_1003, 32'h0000_00AB, SZ_B, 4'b1000, 32'hABAB_ABAB);
    do_store("sh", 32'h0000_1002, 32'h1234_CDEF, SZ_H, 4'b1100, 32'hCDEF_CDEF);
    do_store("sw", 32'h0000_1004, 32'h1122_3344, SZ_W, 4'b1111, 32'h1122_3344);

    do_load("lh",  32'h0000_2002, SZ_H,  32'h8001_1234, 32'hFFFF_8001);
    do_load("lhu", 32'h0000_2002, SZ_HU, 32'h8001_1234, 32'h0000_8001);
    do_load("lb",  32'h0000_1001, SZ_B,  32'h0000_8000, 32'hFFFF_FF80);
    do_load("lbu", 32'h0000_1001, SZ_BU, 32'h0000_8000, 32'h0000_0080);

    // Misaligned word load: no request, no register write
    set_nop();
    mem_read_e = 1'b1;
    rd_write_e = 1'b1;
    mem_size_e = SZ_W;
    alu_res_e  = 32'h0000_3001;
    tick();
    check("mis_lw_flag", misalign_m, 1'b1);
    check("mis_lw_rdw",  rd_write_m, 1'b0);
    check("mis_lw_req",  bus.mem_req, 1'b0);
    check("mis_lw_busy", busy_m, 1'b0);
    check("mis_lw_pcn",  pc_next_addr_m, 32'h0000_3001);
    // D is illegal on a 32-bit datapath
    mem_size_e = SZ_D;
    alu_res_e  = 32'h0000_7000;
    tick();
    check("mis_ld_flag", misalign_m, 1'b1);
    check("mis_ld_req",  bus.mem_req, 1'b0);
    // Reserved size on a store
    set_nop();
    mem_write_e = 1'b1;
    mem_size_e  = 3'b111;
    alu_res_e   = 32'h0000_7000;
    tick();
    set_nop();
    check("mis_s7_flag", misalign_m, 1'b1);
    check("mis_s7_req",  bus.mem_req, 1'b0);
    tick();
    check("mis_after_req", bus.mem_req, 1'b0);
    check("mis_after_flag", misalign_m, 1'b0);

    // Slow word load: ready after 3 cycles, valid 2 later, stall pulse in WAIT
    acc0 = acc_cnt;
    set_nop();
    mem_read_e = 1'b1;
    rd_write_e = 1'b1;
    rd_e       = 5'd7;
    mem_size_e = SZ_W;
    alu_res_e  = 32'h0000_4000;
    tick();
    set_nop();
    for (int i = 0; i < 3; i++) begin
      check("slow_req_hold",  bus.mem_req, 1'b1);
      check("slow_busy_req",  busy_m, 1'b1);
      check("slow_addr_hold", bus.mem_addr, 32'h0000_4000);
      bus.mem_valid = (i == 1);
      tick();
      bus.mem_valid = 1'b0;
    end
    check("slow_req_unsol", bus.mem_req, 1'b1);
    bus.mem_ready = 1'b1;
    tick();
    bus.mem_ready = 1'b0;
    check("slow_wait_req", bus.mem_req, 1'b0);
    stall_m = 1'b1;
    tick();
    check("slow_stall_busy", busy_m, 1'b1);
    check("slow_stall_req",  bus.mem_req, 1'b0);
    stall_m = 1'b0;
    tick();
    check("slow_wait_busy", busy_m, 1'b1);
    bus.mem_rdata = 32'hDEAD_BEEF;
    bus.mem_valid = 1'b1;
    tick();
    bus.mem_valid = 1'b0;
    check("slow_data", mem_read_data_m, 32'hDEAD_BEEF);
    check("slow_busy_end", busy_m, 1'b0);
    check("slow_rd", rd_m, 5'd7);
    check("slow_one_req", acc_cnt - acc0, 1);

    // A load held by stall_m in execute must not launch a request
    mem_read_e = 1'b1;
    mem_size_e = SZ_W;
    alu_res_e  = 32'h0000_4400;
    stall_m    = 1'b1;
    tick();
    tick();
    check("held_req",  bus.mem_req, 1'b0);
    check("held_busy", busy_m, 1'b0);
    check("held_alu",  alu_res_m, 32'h0000_4000);
    set_nop();
    stall_m = 1'b0;
    tick();

    // ALU pass-through with stall toggling
    for (int i = 0; i < 8; i++) begin
      set_nop();
      stall_m    = (i % 3 == 1);
      alu_res_e  = 32'h0000_0100 + 32'(i) * 32'h11;
      pc_e       = 32'h0000_0040 + 32'(i) * 4;
      rd_e       = 5'(i + 1);
      rd_write_e = 1'b1;
      pc_write_e = (i == 2);
      tick();
      if (!stall_m) begin
        exp_alu = alu_res_e;
        exp_pc  = pc_e;
        exp_rd  = rd_e;
        exp_pcw = pc_write_e;
      end
      check("alu_res", alu_res_m, exp_alu);
      check("alu_pc",  pc_m, exp_pc);
      check("alu_rd",  rd_m, exp_rd);
      check("alu_pcw", pc_write_m, exp_pcw);
      check("alu_pcn", pc_next_addr_m, exp_alu);
      check("alu_busy", busy_m, 1'b0);
      check("alu_req",  bus.mem_req, 1'b0);
    end
    stall_m = 1'b0;
    set_nop();
    tick();

    // Asynchronous reset while in WAIT
    mem_read_e = 1'b1;
    rd_write_e = 1'b1;
    rd_e       = 5'd3;
    mem_size_e = SZ_W;
    alu_res_e  = 32'h0000_5004;
    tick();
    set_nop();
    bus.mem_ready = 1'b1;
    tick();
    bus.mem_ready = 1'b0;
    check("rstw_in_wait", busy_m, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rstw_req",   bus.mem_req, 1'b0);
    check("rstw_busy",  busy_m, 1'b0);
    check("rstw_alu",   alu_res_m, 32'h0);
    check("rstw_rd",    rd_m, 5'd0);
    check("rstw_addr",  bus.mem_addr, 32'h0);
    check("rstw_rdata", mem_read_data_m, 32'h0);
    #2;
    rst_n = 1'b1;
    tick();
    do_load("post_rst", 32'h0000_6008, SZ_W, 32'hCAFE_F00D, 32'hCAFE_F00D);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
